// File: rtl/sha256_pad_ctrl_pkg.sv
// Shared constants for the SHA-256 pad sequencer: block geometry, FSM encodings
// and the per-word byte-count helper.
package sha256_pad_ctrl_pkg;

  localparam int PROCB_TOTAL_MSB = 31;
  localparam int SHA_BLK_BYTES   = 64;
  localparam int SHA_LEN_POS     = 60;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_PAD80 = 3'd2;
  localparam logic [2:0] ST_ZERO  = 3'd3;
  localparam logic [2:0] ST_TOTAL = 3'd4;

  function automatic logic [2:0] min_len(input logic [6:0] n, input logic [2:0] cap);
    min_len = (n < {4'd0, cap}) ? n[2:0] : cap;
  endfunction

endpackage

// File: rtl/sha256_pad_ctrl_pad_count.sv
// Pad word length and zero-word count derived from the low six bits of the
// running message byte total.
module sha256_pad_ctrl_pad_count
  import sha256_pad_ctrl_pkg::*;
(
  input  logic [5:0] t_lo,
  output logic [2:0] pad_len,
  output logic [4:0] zero_cnt
);

  localparam logic [3:0] LEN_WORD  = 4'(SHA_LEN_POS / 4);
  localparam logic [4:0] BLK_WORDS = 5'(SHA_BLK_BYTES / 4);

  logic [3:0] pos_w;

  assign pad_len = 3'd4 - {1'b0, t_lo[1:0]};

  // The 0x80 word always ends on the next word boundary, so its aligned word
  // position is simply the current word index plus one, modulo a block.
  assign pos_w = t_lo[5:2] + 4'd1;

  // Landing exactly on the length slot leaves no room: a whole zero block follows.
  assign zero_cnt = (pos_w == LEN_WORD) ? BLK_WORDS : {1'b0, LEN_WORD - pos_w};

endmodule

// File: rtl/sha256_pad_ctrl.sv
// Chunk sequencer in front of the realign/pad stage: fetches message words
// from memory, then appends the 0x80 word, zero words and the total-length word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a chunk command
// ST_DATA  | reading chunk words, one wr_en per word one cycle later
// ST_PAD80 | issue the 0x80 pad word
// ST_ZERO  | issue the remaining zero words
// ST_TOTAL | issue the total-length word; msg_done follows next cycle
module sha256_pad_ctrl
  import sha256_pad_ctrl_pkg::*;
#(
  parameter int ADDR_MSB  = 9,
  parameter int TOTAL_MSB = PROCB_TOTAL_MSB
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_MSB+2:0] cmd_addr,
  input  logic [6:0]          cmd_len,
  input  logic                cmd_finish,
  output logic                mem_rd_en,
  output logic [ADDR_MSB:0]   mem_addr,
  input  logic [31:0]         mem_dout,
  input  logic                eng_ready,
  output logic                wr_en,
  output logic [2:0]          len,
  output logic [1:0]          off,
  output logic [31:0]         din,
  output logic                add0x80pad,
  output logic                add0pad,
  output logic                add_total,
  output logic [TOTAL_MSB:0]  in_total,
  output logic                msg_done,
  output logic                err
);

  logic [2:0]         state;
  logic [ADDR_MSB:0]  word_addr;
  logic [6:0]         n_left;
  logic [1:0]         first_off;
  logic               first_word;
  logic               finish_q;
  logic [TOTAL_MSB:0] total;
  logic [4:0]         zero_left;
  logic [2:0]         pad_len;
  logic [4:0]         zero_cnt;
  logic [2:0]         word_cap;
  logic [2:0]         word_len;
  logic               rd_go;

  sha256_pad_ctrl_pad_count u_pad_count (
    .t_lo     (total[5:0]),
    .pad_len  (pad_len),
    .zero_cnt (zero_cnt)
  );

  assign cmd_ready = (state == ST_IDLE) && !RST;
  assign rd_go     = (state == ST_DATA) && eng_ready && (n_left != 7'd0);
  assign mem_rd_en = rd_go;
  assign mem_addr  = word_addr;
  assign din       = mem_dout;
  assign in_total  = total;
  assign word_cap  = first_word ? (3'd4 - {1'b0, first_off}) : 3'd4;
  assign word_len  = min_len(n_left, word_cap);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      word_addr  <= '0;
      n_left     <= '0;
      first_off  <= '0;
      first_word <= 1'b0;
      finish_q   <= 1'b0;
      total      <= '0;
      zero_left  <= '0;
      wr_en      <= 1'b0;
      len        <= '0;
      off        <= '0;
      add0x80pad <= 1'b0;
      add0pad    <= 1'b0;
      add_total  <= 1'b0;
      msg_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      add0x80pad <= 1'b0;
      add0pad    <= 1'b0;
      add_total  <= 1'b0;
      len        <= '0;
      off        <= '0;
      msg_done   <= add_total;
      if (add_total) total <= '0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == 7'd0) begin
              err <= 1'b1;
            end else begin
              // A total that is being cleared this cycle counts as aligned.
              if (cmd_addr[1:0] != 2'd0 && total[1:0] != 2'd0 && !add_total)
                err <= 1'b1;
              word_addr  <= cmd_addr[ADDR_MSB+2:2];
              first_off  <= cmd_addr[1:0];
              first_word <= 1'b1;
              n_left     <= cmd_len;
              finish_q   <= cmd_finish;
              state      <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rd_go) begin
            wr_en      <= 1'b1;
            len        <= word_len;
            off        <= first_word ? first_off : 2'd0;
            n_left     <= n_left - {4'd0, word_len};
            total      <= total + (TOTAL_MSB+1)'(word_len);
            word_addr  <= word_addr + {{ADDR_MSB{1'b0}}, 1'b1};
            first_word <= 1'b0;
            if (n_left == {4'd0, word_len})
              state <= finish_q ? ST_PAD80 : ST_IDLE;
          end
        end
        ST_PAD80: begin
          if (eng_ready) begin
            add0x80pad <= 1'b1;
            add0pad    <= 1'b1;
            len        <= pad_len;
            zero_left  <= zero_cnt;
            state      <= (zero_cnt == 5'd0) ? ST_TOTAL : ST_ZERO;
          end
        end
        ST_ZERO: begin
          if (eng_ready) begin
            add0pad   <= 1'b1;
            len       <= 3'd4;
            zero_left <= zero_left - 5'd1;
            if (zero_left == 5'd1) state <= ST_TOTAL;
          end
        end
        ST_TOTAL: begin
          if (eng_ready) begin
            add_total <= 1'b1;
            len       <= 3'd4;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// Directed bench for sha256_pad_ctrl: message padding sequences, error flag
// behaviour and asynchronous reset in the middle of padding.
module tb_sha256_pad_ctrl;

  localparam int ADDR_MSB  = 9;
  localparam int TOTAL_MSB = 31;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [ADDR_MSB+2:0] cmd_addr = '0;
  logic [6:0]          cmd_len = '0;
  logic                cmd_finish = 1'b0;
  logic                mem_rd_en;
  logic [ADDR_MSB:0]   mem_addr;
  logic [31:0]         mem_dout = '0;
  logic                eng_ready = 1'b1;
  logic                wr_en;
  logic [2:0]          len;
  logic [1:0]          off;
  logic [31:0]         din;
  logic                add0x80pad;
  logic                add0pad;
  logic                add_total;
  logic [TOTAL_MSB:0]  in_total;
  logic                msg_done;
  logic                err;

  sha256_pad_ctrl #(.ADDR_MSB(ADDR_MSB), .TOTAL_MSB(TOTAL_MSB)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_finish (cmd_finish),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .eng_ready  (eng_ready),
    .wr_en      (wr_en),
    .len        (len),
    .off        (off),
    .din        (din),
    .add0x80pad (add0x80pad),
    .add0pad    (add0pad),
    .add_total  (add_total),
    .in_total   (in_total),
    .msg_done   (msg_done),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:1023];
  always @(posedge CLK) if (mem_rd_en) mem_dout <= mem[mem_addr];

  logic stall_en = 1'b0;
  always @(negedge CLK) eng_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Strobe log, sampled mid-cycle.
  int          dq_len[$];
  int          dq_off[$];
  logic [31:0] dq_din[$];
  int n80 = 0, nzero = 0, ntot = 0, ndone = 0, bad = 0, len80 = 0, nbytes = 0;
  logic [31:0] tot_val = '0, tot80 = '0;
  logic        prev_tot = 1'b0;

  always @(negedge CLK) begin
    if (wr_en) begin
      dq_len.push_back(int'(len));
      dq_off.push_back(int'(off));
      dq_din.push_back(din);
      nbytes += int'(len);
      if (len == 3'd0 || len > 3'd4) bad++;
    end
    if (add0x80pad) begin
      n80++;
      len80 = int'(len);
      tot80 = in_total;
      nbytes += int'(len);
      if (!add0pad || wr_en || add_total) bad++;
    end else if (add0pad) begin
      nzero++;
      nbytes += 4;
      if (len != 3'd4 || wr_en || add_total) bad++;
    end
    if (add_total) begin
      ntot++;
      tot_val = in_total;
      nbytes += 4;
      if (len != 3'd4 || wr_en || in_total != tot80) bad++;
    end
    if (msg_done) ndone++;
    if (msg_done != prev_tot) bad++;
    prev_tot = add_total;
  end

  int b_dq, b80, bz, bt, bd, bbad, bbytes;

  task automatic mark();
    b_dq = dq_len.size(); b80 = n80; bz = nzero; bt = ntot;
    bd = ndone; bbad = bad; bbytes = nbytes;
  endtask

  task automatic send_cmd(input logic [11:0] a, input int l, input logic f);
    int k = 0;
    @(negedge CLK);
    while (!cmd_ready && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = 7'(l); cmd_finish = f;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (ndone == bd && k < 600) begin
      @(negedge CLK);
      k++;
    end
    chk({tag, "_done_seen"}, {31'd0, ndone > bd}, 32'd1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic verify(input string tag, input int nw, input int pl, input int nz,
                        input int itot, input int nb);
    chk({tag, "_nwords"}, dq_len.size() - b_dq, nw);
    chk({tag, "_n80"}, n80 - b80, 1);
    chk({tag, "_len80"}, len80, pl);
    chk({tag, "_zeros"}, nzero - bz, nz);
    chk({tag, "_ntot"}, ntot - bt, 1);
    chk({tag, "_in_total"}, tot_val, itot);
    chk({tag, "_bytes"}, nbytes - bbytes, nb);
    chk({tag, "_ndone"}, ndone - bd, 1);
    chk({tag, "_excl"}, bad - bbad, 0);
  endtask

  task automatic chk_word(input string tag, input int k, input int el, input int eo,
                          input logic [31:0] ed);
    int j = b_dq + k;
    chk({tag, "_present"}, {31'd0, j < dq_len.size()}, 32'd1);
    if (j < dq_len.size()) begin
      chk({tag, "_len"}, dq_len[j], el);
      chk({tag, "_off"}, dq_off[j], eo);
      chk({tag, "_din"}, dq_din[j], ed);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_len", {29'd0, len}, 32'd0);
    chk("rst_off", {30'd0, off}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_in_total", in_total, 32'd0);
    chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);

    // 3 bytes: T=3 -> pad len 1, aligned word 1, 14 zero words
    mark(); send_cmd(12'h000, 3, 1'b1); wait_done("m3");
    verify("m3", 1, 1, 14, 3, 64);
    chk_word("m3_w0", 0, 3, 0, mem[0]);

    // offset 2, 10 bytes: words 2,4,4; T=10 -> pad len 2, 12 zero words
    mark(); send_cmd(12'h102, 10, 1'b1); wait_done("m10");
    verify("m10", 3, 2, 12, 10, 64);
    chk_word("m10_w0", 0, 2, 2, mem[32'h40]);
    chk_word("m10_w1", 1, 4, 0, mem[32'h41]);
    chk_word("m10_w2", 2, 4, 0, mem[32'h42]);

    // 56 aligned bytes with engine stalls: pad lands on the length slot
    mark(); stall_en = 1'b1; send_cmd(12'h200, 56, 1'b1); wait_done("m56"); stall_en = 1'b0;
    verify("m56", 14, 4, 16, 56, 128);
    for (int i = 0; i < 14; i++) chk_word($sformatf("m56_w%0d", i), i, 4, 0, mem[32'h80 + i]);

    // 60 + 4 bytes: T=64 wraps to a fresh block position
    mark(); send_cmd(12'h000, 60, 1'b0); send_cmd(12'h100, 4, 1'b1); wait_done("m64");
    verify("m64", 16, 4, 14, 64, 128);
    chk_word("m64_w15", 15, 4, 0, mem[32'h40]);
    chk("m64_err", {31'd0, err}, 32'd0);

    // misaligned continuation: 5 bytes then offset 1 with T mod 4 = 1
    mark(); send_cmd(12'h000, 5, 1'b0); send_cmd(12'h001, 4, 1'b1); wait_done("m9");
    verify("m9", 4, 3, 12, 9, 64);
    chk_word("m9_w1", 1, 1, 0, mem[1]);
    chk_word("m9_w2", 2, 3, 1, mem[0]);
    chk_word("m9_w3", 3, 1, 0, mem[1]);
    chk("m9_err_sticky", {31'd0, err}, 32'd1);

    // reset while zero words are being issued
    mark(); send_cmd(12'h000, 8, 1'b1);
    k = 0;
    while (!(add0pad && !add0x80pad) && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("rz_reached_zero", {31'd0, add0pad && !add0x80pad}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rz_add0pad", {31'd0, add0pad}, 32'd0);
    chk("rz_add0x80pad", {31'd0, add0x80pad}, 32'd0);
    chk("rz_add_total", {31'd0, add_total}, 32'd0);
    chk("rz_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rz_len", {29'd0, len}, 32'd0);
    chk("rz_err", {31'd0, err}, 32'd0);
    chk("rz_in_total", in_total, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rz_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // message after reset starts from T=0
    mark(); send_cmd(12'h000, 8, 1'b1); wait_done("m8");
    verify("m8", 2, 4, 12, 8, 64);
    chk_word("m8_w1", 1, 4, 0, mem[1]);

    // zero-length command is dropped and flags an error
    mark(); send_cmd(12'h000, 0, 1'b1);
    repeat (10) @(negedge CLK);
    chk("z0_err", {31'd0, err}, 32'd1);
    chk("z0_nwords", dq_len.size() - b_dq, 0);
    chk("z0_ntot", ntot - bt, 0);
    chk("z0_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
